matmul_controller: RTL and testbench

- Sequences one matrix multiply C = A x B over three single-port matrix memories: A (ROW x INNER), B (INNER x COL) and C (ROW x COL).
- Drives the read ports of A and B, which are asynchronous-read and active on the read enable, and multiply-accumulates one term per cycle.
- Writes each finished C element through C's synchronous write port.
- Sits between the top-level start/done handshake and the memory instances.

---
 rtl/matmul_controller.sv | 142 ++++++++++++++
 tb/tb_matmul_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_controller.sv
// Sequences one C = A x B over single-port A/B/C memories.
// Ports: clk/rst, start/busy/done/overflow, A/B read ports, C write port.
module matmul_controller #(
  parameter int ROW      = 2,
  parameter int INNER    = 2,
  parameter int COL      = 2,
  parameter int SIZE     = 8,
  parameter int OUT_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                a_read,
  output logic [5:0]          a_read_address,
  input  logic [SIZE-1:0]     a_data,
  output logic                b_read,
  output logic [5:0]          b_read_address,
  input  logic [SIZE-1:0]     b_data,
  output logic                c_write,
  output logic [5:0]          c_write_address,
  output logic [OUT_SIZE-1:0] c_write_value
);

  localparam int ACC_W = 2*SIZE+6;

  localparam logic [5:0] K_LAST = 6'(INNER-1);
  localparam logic [5:0] J_LAST = 6'(COL-1);
  localparam logic [5:0] I_LAST = 6'(ROW-1);

  localparam logic [ACC_W-1:0] C_MAX =
    ACC_W'((64'd1 << OUT_SIZE) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [5:0]       i, j, k;
  logic [5:0]       i_n, j_n, k_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [ACC_W-1:0] prod;
  logic             ovf_n;

  assign prod = ACC_W'(a_data) * ACC_W'(b_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      i        <= i_n;
      j        <= j_n;
      k        <= k_n;
      acc      <= acc_n;
      overflow <= ovf_n;
    end
  end

  always_comb begin
    state_n         = state;
    i_n             = i;
    j_n             = j;
    k_n             = k;
    acc_n           = acc;
    ovf_n           = overflow;
    busy            = 1'b0;
    done            = 1'b0;
    a_read          = 1'b0;
    b_read          = 1'b0;
    c_write         = 1'b0;
    a_read_address  = '0;
    b_read_address  = '0;
    c_write_address = '0;
    c_write_value   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = MAC;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
          acc_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      MAC: begin
        busy   = 1'b1;
        a_read = 1'b1;
        b_read = 1'b1;
        a_read_address =
          6'(32'(i) * INNER + 32'(k));
        b_read_address =
          6'(32'(k) * COL + 32'(j));
        acc_n = acc + prod;
        if (k == K_LAST) begin
          state_n = WRITE;
        end else begin
          k_n = k + 6'd1;
        end
      end
      WRITE: begin
        busy    = 1'b1;
        c_write = 1'b1;
        c_write_address =
          6'(32'(i) * COL + 32'(j));
        c_write_value = acc[OUT_SIZE-1:0];
        // Overflow looks at the full accumulator,
        // not the truncated value written out.
        ovf_n = overflow | (acc > C_MAX);
        acc_n = '0;
        k_n   = '0;
        if (j != J_LAST) begin
          j_n     = j + 6'd1;
          state_n = MAC;
        end else if (i != I_LAST) begin
          j_n     = '0;
          i_n     = i + 6'd1;
          state_n = MAC;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_controller.sv
// Directed bench for matmul_controller with a write scoreboard.
// Two instances: default 2x2x2 and a 3x2x1 variant.
module tb_matmul_controller;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] val;
  } exp_t;

  logic clk;
  logic rst;
  logic start0, start1;

  logic       busy0, done0, ovf0;
  logic       a_rd0, b_rd0, c_wr0;
  logic [5:0] a_ad0, b_ad0, c_ad0;
  logic [7:0] a_d0, b_d0, c_v0;

  logic       busy1, done1, ovf1;
  logic       a_rd1, b_rd1, c_wr1;
  logic [5:0] a_ad1, b_ad1, c_ad1;
  logic [7:0] a_d1, b_d1, c_v1;

  logic [7:0] a0 [64];
  logic [7:0] b0 [64];
  logic [7:0] c0 [64];
  logic [7:0] a1 [64];
  logic [7:0] b1 [64];
  logic [7:0] c1 [64];

  exp_t q0[$];
  exp_t q1[$];

  int n_pass = 0;
  int n_fail = 0;
  int wr0 = 0;
  int wr1 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  matmul_controller u0 (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .done(done0), .overflow(ovf0),
    .a_read(a_rd0), .a_read_address(a_ad0),
    .a_data(a_d0),
    .b_read(b_rd0), .b_read_address(b_ad0),
    .b_data(b_d0),
    .c_write(c_wr0), .c_write_address(c_ad0),
    .c_write_value(c_v0)
  );

  matmul_controller #(
    .ROW(3), .INNER(2), .COL(1)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1), .overflow(ovf1),
    .a_read(a_rd1), .a_read_address(a_ad1),
    .a_data(a_d1),
    .b_read(b_rd1), .b_read_address(b_ad1),
    .b_data(b_d1),
    .c_write(c_wr1), .c_write_address(c_ad1),
    .c_write_value(c_v1)
  );

  assign a_d0 = a_rd0 ? a0[a_ad0] : '0;
  assign b_d0 = b_rd0 ? b0[b_ad0] : '0;
  assign a_d1 = a_rd1 ? a1[a_ad1] : '0;
  assign b_d1 = b_rd1 ? b1[b_ad1] : '0;

  always @(posedge clk) begin
    if (c_wr0) c0[c_ad0] <= c_v0;
    if (c_wr1) c1[c_ad1] <= c_v1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (c_wr0) begin
      wr0++;
      if (q0.size() == 0) begin
        check("c0_unexpected_write", 32'(c_ad0), 99);
      end else begin
        e = q0.pop_front();
        check("c0_addr", 32'(c_ad0), 32'(e.addr));
        check("c0_val", 32'(c_v0), 32'(e.val));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (c_wr1) begin
      wr1++;
      if (q1.size() == 0) begin
        check("c1_unexpected_write", 32'(c_ad1), 99);
      end else begin
        e = q1.pop_front();
        check("c1_addr", 32'(c_ad1), 32'(e.addr));
        check("c1_val", 32'(c_v1), 32'(e.val));
      end
    end
  end

  task automatic push0(input logic [5:0] ad,
                       input logic [7:0] v);
    exp_t e;
    e.addr = ad;
    e.val  = v;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [5:0] ad,
                       input logic [7:0] v);
    exp_t e;
    e.addr = ad;
    e.val  = v;
    q1.push_back(e);
  endtask

  task automatic push4(input logic [7:0] v0, v1,
                       input logic [7:0] v2, v3);
    push0(6'd0, v0);
    push0(6'd1, v1);
    push0(6'd2, v2);
    push0(6'd3, v3);
  endtask

  task automatic set_a0(input logic [7:0] x0, x1,
                        input logic [7:0] x2, x3);
    a0[0] = x0; a0[1] = x1;
    a0[2] = x2; a0[3] = x3;
  endtask

  task automatic set_b0(input logic [7:0] x0, x1,
                        input logic [7:0] x2, x3);
    b0[0] = x0; b0[1] = x1;
    b0[2] = x2; b0[3] = x3;
  endtask

  // Pulse start, then sample each cycle after the
  // accept edge (cycle 1 is the first sample).
  task automatic run(input int sel,
                     output int first_busy,
                     output int nbusy,
                     output int done_at);
    logic b, d;
    @(negedge clk);
    if (sel == 1) start1 = 1'b1;
    else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    first_busy = -1;
    nbusy = 0;
    done_at = -1;
    for (int n = 1; n <= 60; n++) begin
      b = (sel == 1) ? busy1 : busy0;
      d = (sel == 1) ? done1 : done0;
      if (b) begin
        nbusy++;
        if (first_busy < 0) first_busy = n;
      end
      if (d) begin
        done_at = n;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    d = (sel == 1) ? done1 : done0;
    check("done_one_cycle", 32'(d), 0);
  endtask

  int fb, nb, da;
  int d1, d2, nd, w1, wb;
  logic ba1, ba2;

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int n = 0; n < 64; n++) begin
      a0[n] = '0; b0[n] = '0; c0[n] = '0;
      a1[n] = '0; b1[n] = '0; c1[n] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_ovf", 32'(ovf0), 0);
    check("rst_rd_wr", 32'({a_rd0, b_rd0, c_wr0}), 0);
    check("rst_a_addr", 32'(a_ad0), 0);
    check("rst_b_addr", 32'(b_ad0), 0);
    check("rst_c_addr", 32'(c_ad0), 0);
    check("rst_c_val", 32'(c_v0), 0);
    rst = 1'b0;

    // Small values, no overflow
    set_a0(1, 2, 3, 4);
    set_b0(1, 2, 3, 4);
    push4(7, 10, 15, 22);
    run(0, fb, nb, da);
    check("t1_first_busy", 32'(fb), 1);
    check("t1_busy_cycles", 32'(nb), 12);
    check("t1_done_at", 32'(da), 13);
    check("t1_ovf", 32'(ovf0), 0);
    check("t1_q_empty", 32'(q0.size()), 0);
    check("t1_c00", 32'(c0[0]), 7);
    check("t1_c01", 32'(c0[1]), 10);
    check("t1_c10", 32'(c0[2]), 15);
    check("t1_c11", 32'(c0[3]), 22);

    // Truncation and overflow
    set_a0(4, 15, 29, 2);
    set_b0(4, 15, 29, 2);
    push4(195, 90, 174, 183);
    run(0, fb, nb, da);
    check("t2_done_at", 32'(da), 13);
    check("t2_ovf", 32'(ovf0), 1);
    check("t2_q_empty", 32'(q0.size()), 0);

    // Identity clears overflow, then zero A
    set_a0(1, 0, 0, 1);
    set_b0(9, 8, 7, 6);
    push4(9, 8, 7, 6);
    run(0, fb, nb, da);
    check("t3_done_at", 32'(da), 13);
    check("t3_ovf", 32'(ovf0), 0);
    check("t3_q_empty", 32'(q0.size()), 0);
    set_a0(0, 0, 0, 0);
    push4(0, 0, 0, 0);
    run(0, fb, nb, da);
    check("t3z_ovf", 32'(ovf0), 0);
    check("t3z_q_empty", 32'(q0.size()), 0);

    // Start held high: back-to-back runs
    set_a0(1, 0, 0, 1);
    push4(9, 8, 7, 6);
    push4(9, 8, 7, 6);
    wb = wr0;
    d1 = -1; d2 = -1; nd = 0; w1 = -1;
    ba1 = 1'bx; ba2 = 1'bx;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 80; n++) begin
      if (done0) begin
        nd++;
        if (d1 < 0) begin
          d1 = n;
          w1 = wr0 - wb;
        end else begin
          d2 = n;
        end
      end
      if (d1 > 0 && n == d1 + 1) ba1 = busy0;
      if (d1 > 0 && n == d1 + 2) begin
        ba2 = busy0;
        start0 = 1'b0;
      end
      if (d2 > 0) break;
      @(negedge clk);
    end
    check("t4_done1_at", 32'(d1), 13);
    check("t4_writes_run1", 32'(w1), 4);
    check("t4_idle_gap_busy", 32'(ba1), 0);
    check("t4_restart_busy", 32'(ba2), 1);
    check("t4_done2_at", 32'(d2), 27);
    check("t4_done_pulses", 32'(nd), 2);
    check("t4_writes_total", 32'(wr0 - wb), 8);
    check("t4_q_empty", 32'(q0.size()), 0);
    @(negedge clk);

    // Asynchronous reset mid-run
    push0(6'd0, 9);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_before", 32'(busy0), 1);
    check("t5_a_read_before", 32'(a_rd0), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_busy_async", 32'(busy0), 0);
    check("t5_cwr_async", 32'(c_wr0), 0);
    check("t5_done_async", 32'(done0), 0);
    check("t5_a_read_async", 32'(a_rd0), 0);
    wb = wr0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_writes", 32'(wr0 - wb), 0);
    check("t5_q_empty", 32'(q0.size()), 0);
    push4(9, 8, 7, 6);
    run(0, fb, nb, da);
    check("t5_rerun_done_at", 32'(da), 13);
    check("t5_rerun_busy", 32'(nb), 12);
    check("t5_rerun_q_empty", 32'(q0.size()), 0);

    // 3x2x1 instance
    a1[0] = 1; a1[1] = 1;
    a1[2] = 2; a1[3] = 2;
    a1[4] = 3; a1[5] = 3;
    b1[0] = 5; b1[1] = 6;
    push1(6'd0, 11);
    push1(6'd1, 22);
    push1(6'd2, 33);
    run(1, fb, nb, da);
    check("t6_first_busy", 32'(fb), 1);
    check("t6_busy_cycles", 32'(nb), 9);
    check("t6_done_at", 32'(da), 10);
    check("t6_ovf", 32'(ovf1), 0);
    check("t6_q_empty", 32'(q1.size()), 0);
    check("t6_writes", 32'(wr1), 3);
    check("t6_c0", 32'(c1[0]), 11);
    check("t6_c1", 32'(c1[1]), 22);
    check("t6_c2", 32'(c1[2]), 33);

    $display("%0d/%0d checks passed",
             n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
